tiny_prog_loader: RTL and testbench
===================================

// Module: tiny_prog_loader
// PURPOSE
//  Writer side of the TinySoC program-memory interface: receives a program image from the UART RX
//  byte stream and writes it into program RAM (addr/data/we), replacing the hard-coded program.
//  Holds the CPU in reset while loading and releases it after a valid image is received.
//  Sits between uart_rx and the program RAM write port; the CPU keeps the read port.
// PARAMETERS
//  BASE_ADDR      8'h00   first RAM address written by each image
//  GAP_CYCLES     100000  max clk cycles between bytes inside a frame before abort (>=2)
// PORTS
//  clk        in   1  system clock
//  rst        in   1  synchronous, active-high reset
//  rx_data    in   8  byte from uart_rx, valid when rx_valid=1
//  rx_valid   in   1  one-cycle strobe per received byte
//  reload     in   1  one-cycle pulse: re-enter SYNC, re-assert cpu_hold
//  mem_we     out  1  program RAM write enable (one-cycle pulse per data byte)
//  mem_addr   out  8  program RAM write address
//  mem_wdata  out  8  program RAM write data
//  cpu_hold   out  1  1 = CPU held in reset
//  load_done  out  1  1 while a valid image is running (state RUN)
//  load_err   out  1  sticky error flag: checksum mismatch or inter-byte timeout
// BEHAVIOUR
//  Frame: 0xA5 sync, LEN (0 means 256), LEN data bytes, CSUM (with LOADER_CSUM_EN).
//  Reset: state=SYNC, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, cpu_hold=1, load_done=0, load_err=0.
//  SYNC: rx_valid & rx_data==8'hA5 -> LEN and clear load_err; any other byte ignored.
//  LEN:  rx_valid -> latch count (0 maps to 256), mem_addr=BASE_ADDR, sum=0 -> DATA.
//  DATA: rx_valid -> registered write: next cycle mem_we=1, mem_wdata=byte, mem_addr=current address.
//    Address increments after each write, wrapping 8'hFF->8'h00. sum += byte (mod 256).
//    Last byte -> CSUM (macro defined) or RUN (macro undefined).
//  CSUM: rx_valid: byte==sum -> RUN; mismatch -> load_err=1, SYNC.
//  RUN:  cpu_hold=0, load_done=1; rx bytes ignored. reload -> SYNC, cpu_hold=1 next cycle.
//  cpu_hold and load_done are registered: they change the cycle after entry into or exit from RUN.
//  Gap timer: runs only in LEN/DATA/CSUM, clears on every rx_valid.
//    Reaching GAP_CYCLES -> load_err=1, SYNC.
//  A partial image is never erased; RAM keeps the bytes already written after an abort.
//  Simultaneous events: rst > reload > timeout > rx_valid.
//    reload in any state -> SYNC; a byte arriving in the same cycle is dropped.
//  rst mid-frame: immediate return to the reset values; any pending write pulse is cancelled.
//  mem_we never asserted outside DATA; at most one write per rx_valid.
// CONFIGURATION
//  LOADER_CSUM_EN defined: CSUM state present; mismatch gives load_err and no RUN.
//  LOADER_CSUM_EN undefined: no CSUM byte expected; last data byte -> RUN; load_err only from timeout.
// STRUCTURE
//  tiny_soc_pkg holds:
//    state encodings (S_SYNC, S_LEN, S_DATA, S_CSUM, S_RUN)
//    LOADER_SYNC_BYTE = 8'hA5
//  Sub-module tiny_gap_timer: counter with clear/enable and a timeout strobe.
//    Width is $clog2(GAP_CYCLES+1).
//  FSM, address counter, length counter and sum live in tiny_prog_loader.
// TESTING
//  1. A5,03,15,21,31,67 (CSUM on) -> writes 00:15 01:21 02:31; cpu_hold 1->0; load_done=1; load_err=0.
//  2. A5,02,15,21,00 -> no RUN, load_err=1, cpu_hold=1.
//     Then A5 -> load_err clears; RAM 00:15 01:21 retained.
//  3. Bytes 12,A5,01,68,68 -> 12 ignored; single write 00:68; RUN.
//  4. A5,00 then 256 bytes i=0..255 plus CSUM 80 -> 256 writes, addr 00..FF.
//     No extra write, no wrap overwrite; RUN.
//  5. A5,04,15 then idle GAP_CYCLES -> load_err=1, state SYNC, cpu_hold=1.
//     Also: reload pulse in RUN -> cpu_hold=1 next cycle, next A5 accepted.
//  6. rst during DATA after 2 of 4 bytes -> all outputs at reset values next cycle.
//     Following byte 21 ignored until A5.

Source files
------------

// File: rtl/tiny_soc_pkg.sv
// Shared TinySoC types: program-loader state encoding and frame constants.
// No ports; imported with import tiny_soc_pkg::*.
package tiny_soc_pkg;

  typedef enum logic [2:0] {
    S_SYNC = 3'd0,
    S_LEN  = 3'd1,
    S_DATA = 3'd2,
    S_CSUM = 3'd3,
    S_RUN  = 3'd4
  } loader_state_t;

  localparam logic [7:0] LOADER_SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/tiny_gap_timer.sv
// Inter-byte gap timer: counts enabled idle cycles, strobes timeout at limit.
// Ports: clk, rst (sync, high), clr, en in; timeout out (combinational).
module tiny_gap_timer #(
  parameter int GAP_CYCLES = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic timeout
);

  localparam int W = $clog2(GAP_CYCLES + 1);
  // cnt holds idle cycles seen since the last clear; the
  // GAP_CYCLES-th idle edge is the one that sees cnt == LIMIT.
  localparam logic [W-1:0] LIMIT = W'(GAP_CYCLES - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en && cnt != LIMIT) begin
      cnt <= cnt + W'(1);
    end
  end

  assign timeout = en & (cnt == LIMIT);

endmodule

// File: rtl/tiny_prog_loader.sv
// UART program loader: A5, LEN, data, [CSUM] frame -> program RAM writes.
// Ports: clk, rst, rx_data/rx_valid, reload in; mem_we/addr/wdata,
// cpu_hold, load_done, load_err out. Macro LOADER_CSUM_EN adds CSUM byte.
module tiny_prog_loader #(
  parameter logic [7:0] BASE_ADDR  = 8'h00,
  parameter int         GAP_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       reload,
  output logic       mem_we,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  output logic       cpu_hold,
  output logic       load_done,
  output logic       load_err
);

  import tiny_soc_pkg::*;

  loader_state_t state;
  logic [7:0]    wr_addr;
  logic [8:0]    left;
`ifdef LOADER_CSUM_EN
  logic [7:0]    sum;
`endif
  logic          active;
  logic          timeout;
  logic          tmr_clr;

  assign active = (state == S_LEN) ||
                  (state == S_DATA) ||
                  (state == S_CSUM);

  assign tmr_clr = rx_valid | reload | ~active;

  tiny_gap_timer #(
    .GAP_CYCLES(GAP_CYCLES)
  ) u_gap (
    .clk    (clk),
    .rst    (rst),
    .clr    (tmr_clr),
    .en     (active),
    .timeout(timeout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_SYNC;
      wr_addr   <= BASE_ADDR;
      left      <= '0;
`ifdef LOADER_CSUM_EN
      sum       <= '0;
`endif
      mem_we    <= 1'b0;
      mem_addr  <= BASE_ADDR;
      mem_wdata <= '0;
      cpu_hold  <= 1'b1;
      load_done <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      mem_we    <= 1'b0;
      // Lag state by one cycle on entry/exit of RUN.
      cpu_hold  <= (state != S_RUN);
      load_done <= (state == S_RUN);
      if (reload) begin
        state <= S_SYNC;
      end else if (timeout) begin
        load_err <= 1'b1;
        state    <= S_SYNC;
      end else if (rx_valid) begin
        unique case (state)
          S_SYNC: begin
            if (rx_data == LOADER_SYNC_BYTE) begin
              load_err <= 1'b0;
              state    <= S_LEN;
            end
          end
          S_LEN: begin
            left     <= (rx_data == 8'h00) ? 9'd256
                                           : {1'b0, rx_data};
            wr_addr  <= BASE_ADDR;
            mem_addr <= BASE_ADDR;
`ifdef LOADER_CSUM_EN
            sum      <= '0;
`endif
            state    <= S_DATA;
          end
          S_DATA: begin
            mem_we    <= 1'b1;
            mem_wdata <= rx_data;
            mem_addr  <= wr_addr;
            wr_addr   <= wr_addr + 8'd1;
            left      <= left - 9'd1;
`ifdef LOADER_CSUM_EN
            sum       <= sum + rx_data;
            if (left == 9'd1) state <= S_CSUM;
`else
            if (left == 9'd1) state <= S_RUN;
`endif
          end
          S_CSUM: begin
`ifdef LOADER_CSUM_EN
            if (rx_data == sum) begin
              state <= S_RUN;
            end else begin
              load_err <= 1'b1;
              state    <= S_SYNC;
            end
`else
            state <= S_SYNC;
`endif
          end
          S_RUN: begin
          end
          default: state <= S_SYNC;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tiny_prog_loader.sv
// Self-checking bench for tiny_prog_loader: directed frames plus random
// frames against a frame-level RAM/status model.
module tb_tiny_prog_loader;

  localparam int GAP = 40;
`ifdef LOADER_CSUM_EN
  localparam bit CSUM_ON = 1'b1;
`else
  localparam bit CSUM_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       reload = 1'b0;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       cpu_hold;
  logic       load_done;
  logic       load_err;

  tiny_prog_loader #(
    .BASE_ADDR (8'h00),
    .GAP_CYCLES(GAP)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .reload   (reload),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .cpu_hold (cpu_hold),
    .load_done(load_done),
    .load_err (load_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [7:0] ram [256];
  logic [7:0] m_ram [256];
  int         writes = 0;
  int         m_writes = 0;
  logic       m_run = 1'b0;
  logic       m_err = 1'b0;

  // Capture writes; pre-NBA values at posedge are last cycle's outputs.
  always @(posedge clk) begin
    if (mem_we) begin
      ram[mem_addr] = mem_wdata;
      writes++;
    end
  end

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
    repeat ($urandom_range(0, 3)) @(negedge clk);
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    tick(2);
    m_run = 1'b0;
  endtask

  // Frame-level reference: bytes land at consecutive addresses from 0,
  // image runs iff checksum is off or equals the byte sum mod 256.
  task automatic frame(logic [7:0] d[$], logic [7:0] cs);
    int         len;
    logic [7:0] s;
    len = d.size();
    s = 8'h00;
    send(8'hA5);
    send(8'(len));
    foreach (d[i]) begin
      send(d[i]);
      s = s + d[i];
      m_ram[i % 256] = d[i];
    end
    if (CSUM_ON) send(cs);
    m_writes += len;
    m_run = !CSUM_ON || (cs == s);
    m_err = !m_run;
    tick(3);
  endtask

  task automatic chk_status(string tag);
    chk({tag, ".hold"}, 32'(cpu_hold), 32'(!m_run));
    chk({tag, ".done"}, 32'(load_done), 32'(m_run));
    chk({tag, ".err"}, 32'(load_err), 32'(m_err));
    chk({tag, ".writes"}, 32'(writes), 32'(m_writes));
  endtask

  task automatic chk_ram(string tag);
    int bad;
    bad = 0;
    for (int a = 0; a < 256; a++)
      if (ram[a] !== m_ram[a]) bad++;
    chk({tag, ".ram_bad"}, 32'(bad), 32'd0);
  endtask

  task automatic chk_reset(string tag);
    chk({tag, ".we"}, 32'(mem_we), 32'd0);
    chk({tag, ".addr"}, 32'(mem_addr), 32'h00);
    chk({tag, ".wdata"}, 32'(mem_wdata), 32'h00);
    chk({tag, ".hold"}, 32'(cpu_hold), 32'd1);
    chk({tag, ".done"}, 32'(load_done), 32'd0);
    chk({tag, ".err"}, 32'(load_err), 32'd0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] q[$];
    logic [7:0] s;
    logic [7:0] b;
    int         len;

    for (int a = 0; a < 256; a++) begin
      ram[a]   = 8'h00;
      m_ram[a] = 8'h00;
    end

    rst = 1'b1;
    tick(3);
    chk_reset("reset");
    rst = 1'b0;
    tick(1);

    // 1: basic image
    frame('{8'h15, 8'h21, 8'h31}, 8'h67);
    chk_status("t1");
    chk_ram("t1");

    // 2: bad checksum, then A5 clears the error
    pulse_reload();
    chk("t2.reload_hold", 32'(cpu_hold), 32'd1);
    chk("t2.reload_done", 32'(load_done), 32'd0);
    frame('{8'h15, 8'h21}, 8'h00);
    chk_status("t2");
    send(8'hA5);
    tick(2);
    m_err = 1'b0;
    chk("t2.err_clear", 32'(load_err), 32'd0);
    pulse_reload();
    chk_ram("t2");

    // 3: junk before sync is ignored
    send(8'h12);
    frame('{8'h68}, 8'h68);
    chk_status("t3");
    chk_ram("t3");

    // 4: LEN=0 means 256 bytes
    pulse_reload();
    q = {};
    for (int i = 0; i < 256; i++) q.push_back(8'(i));
    frame(q, 8'h80);
    chk_status("t4");
    chk_ram("t4");

    // random frames, checksum good or corrupted
    for (int k = 0; k < 6; k++) begin
      pulse_reload();
      b = 8'($urandom);
      if (b == 8'hA5) b = 8'h00;
      send(b);
      len = $urandom_range(1, 24);
      q = {};
      s = 8'h00;
      for (int i = 0; i < len; i++) begin
        q.push_back(8'($urandom));
        s = s + q[i];
      end
      if ($urandom_range(0, 1) == 1) s = s ^ 8'h5A;
      frame(q, s);
      chk_status($sformatf("rnd%0d", k));
      chk_ram($sformatf("rnd%0d", k));
    end

    // 5: inter-byte timeout
    pulse_reload();
    send(8'hA5);
    send(8'h04);
    send(8'h15);
    m_ram[0] = 8'h15;
    m_writes += 1;
    tick(GAP - 8);
    chk("t5.err_early", 32'(load_err), 32'd0);
    tick(12);
    m_err = 1'b1;
    chk("t5.err", 32'(load_err), 32'd1);
    chk("t5.hold", 32'(cpu_hold), 32'd1);
    chk("t5.done", 32'(load_done), 32'd0);
    chk_ram("t5");
    frame('{8'h42}, 8'h42);
    chk_status("t5r");

    // 6: reset in the middle of DATA
    pulse_reload();
    send(8'hA5);
    send(8'h04);
    send(8'h15);
    send(8'h21);
    m_ram[0] = 8'h15;
    m_ram[1] = 8'h21;
    m_writes += 2;
    rst = 1'b1;
    @(negedge clk);
    chk_reset("t6.rst");
    rst = 1'b0;
    m_run = 1'b0;
    m_err = 1'b0;
    send(8'h21);
    tick(3);
    chk_status("t6.idle");
    frame('{8'h33}, 8'h33);
    chk_status("t6");
    chk_ram("t6");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
